pick_controller: RTL and testbench

- Upstream stage of each lock level (easy/medium/hard). Converts the keyboard keycode into the pick position and the open-attempt strobe that the level modules consume.
- Pick position is `pickY` (pin row) and `pickLRx` (insertion depth). The open-attempt strobe is `openner`, active-low.
- Motion updates once per video frame and follows an insert/probe/retract state machine.
- Outputs feed both the level logic and the pick sprite renderer.

---
 rtl/pick_controller_pkg.sv | 32 +++
 rtl/pick_controller_frame_tick.sv | 26 ++
 rtl/pick_controller.sv | 158 +++++++++++++++
 tb/tb_pick_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pick_controller_pkg.sv
// Shared keycodes, FSM encodings and default pick geometry for the lock-pick
// controller and its frame-tick helper.
package pick_pkg;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  typedef enum logic [1:0] {
    P_OUT  = 2'd0,
    P_MOVE = 2'd1,
    P_IN   = 2'd2,
    P_TRY  = 2'd3
  } pick_state_t;

  typedef enum logic {
    DIR_INSERT  = 1'b0,
    DIR_RETRACT = 1'b1
  } pick_dir_t;

  localparam int X_OUT_DEF      = 600;
  localparam int X_IN_DEF       = 480;
  localparam int X_STEP_DEF     = 8;
  localparam int Y_MIN_DEF      = 32;
  localparam int Y_MAX_DEF      = 479;
  localparam int Y_STEP_DEF     = 4;
  localparam int Y_INIT_DEF     = 46;
  localparam int TRY_FRAMES_DEF = 2;

endpackage

// File: rtl/pick_controller_frame_tick.sv
// Brings the asynchronous frame clock into the Clk domain and emits a single
// Clk-wide pulse on each of its rising edges.
module frame_tick (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic tick_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick_o = sync2_q & ~prev_q;

endmodule

// File: rtl/pick_controller.sv
// Keyboard-driven lock-pick motion: insert/probe/retract FSM advanced once per
// video frame, producing pick position and the active-low open-attempt strobe.
module pick_controller
  import pick_pkg::*;
#(
  parameter int X_OUT      = X_OUT_DEF,
  parameter int X_IN       = X_IN_DEF,
  parameter int X_STEP     = X_STEP_DEF,
  parameter int Y_MIN      = Y_MIN_DEF,
  parameter int Y_MAX      = Y_MAX_DEF,
  parameter int Y_STEP     = Y_STEP_DEF,
  parameter int Y_INIT     = Y_INIT_DEF,
  parameter int TRY_FRAMES = TRY_FRAMES_DEF
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       frame_clk,
  input  logic       level_active,
  input  logic [7:0] keycode,
  output logic [9:0] pickY,
  output logic [9:0] pickLRx,
  output logic       openner,
  output logic [1:0] pick_state
);

  localparam logic [9:0]  XOUT10  = 10'(X_OUT);
  localparam logic [9:0]  XIN10   = 10'(X_IN);
  localparam logic [9:0]  XSTEP10 = 10'(X_STEP);
  localparam logic [9:0]  YMIN10  = 10'(Y_MIN);
  localparam logic [9:0]  YMAX10  = 10'(Y_MAX);
  localparam logic [9:0]  YSTEP10 = 10'(Y_STEP);
  localparam logic [9:0]  YINIT10 = 10'(Y_INIT);
  localparam logic [10:0] XOUT11  = 11'(X_OUT);
  localparam logic [10:0] XIN11   = 11'(X_IN);
  localparam logic [10:0] XSTEP11 = 11'(X_STEP);
  localparam logic [10:0] YMIN11  = 11'(Y_MIN);
  localparam logic [10:0] YMAX11  = 11'(Y_MAX);
  localparam logic [10:0] YSTEP11 = 11'(Y_STEP);
  localparam logic [7:0]  TRY_LD  = 8'(TRY_FRAMES - 1);

  pick_state_t state_q;
  pick_dir_t   dir_q;
  logic [9:0]  pickY_q, pickLRx_q;
  logic        openner_q, space_armed_q;
  logic [7:0]  try_cnt_q;
  logic        tick;

  frame_tick u_tick (
    .clk_i   (Clk),
    .rst_n_i (reset),
    .async_i (frame_clk),
    .tick_o  (tick)
  );

  // 11-bit arithmetic so saturation tests cannot wrap at the 10-bit limit.
  logic [10:0] y_ext, x_ext;
  logic [9:0]  y_up_d, y_dn_d, y_key_d;
  logic        ins_done, ret_done, attempt;

  assign y_ext    = {1'b0, pickY_q};
  assign x_ext    = {1'b0, pickLRx_q};
  assign y_up_d   = (y_ext < YMIN11 + YSTEP11) ? YMIN10 : pickY_q - YSTEP10;
  assign y_dn_d   = (y_ext + YSTEP11 > YMAX11) ? YMAX10 : pickY_q + YSTEP10;
  assign y_key_d  = (keycode == KEY_W) ? y_up_d :
                    (keycode == KEY_S) ? y_dn_d : pickY_q;
  assign ins_done = (x_ext <= XIN11 + XSTEP11);
  assign ret_done = (x_ext + XSTEP11 >= XOUT11);
  assign attempt  = tick && level_active && (state_q == P_IN) &&
                    (keycode == KEY_SPACE) && space_armed_q;

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q       <= P_OUT;
      dir_q         <= DIR_INSERT;
      pickLRx_q     <= XOUT10;
      pickY_q       <= YINIT10;
      openner_q     <= 1'b1;
      space_armed_q <= 1'b1;
      try_cnt_q     <= '0;
    end else begin
      if (attempt)                space_armed_q <= 1'b0;
      else if (keycode != KEY_SPACE) space_armed_q <= 1'b1;

      if (tick && !level_active) begin
        openner_q <= 1'b1;
        try_cnt_q <= '0;
        if (state_q == P_OUT) begin
          pickLRx_q <= XOUT10;
        end else if (state_q == P_MOVE && dir_q == DIR_RETRACT) begin
          if (ret_done) begin
            pickLRx_q <= XOUT10;
            state_q   <= P_OUT;
          end else begin
            pickLRx_q <= pickLRx_q + XSTEP10;
          end
        end else begin
          state_q <= P_MOVE;
          dir_q   <= DIR_RETRACT;
        end
      end else if (tick) begin
        unique case (state_q)
          P_OUT: begin
            pickLRx_q <= XOUT10;
            pickY_q   <= y_key_d;
            if (keycode == KEY_D) begin
              state_q <= P_MOVE;
              dir_q   <= DIR_INSERT;
            end
          end
          P_MOVE: begin
            if (dir_q == DIR_INSERT) begin
              if (keycode == KEY_A) begin
                dir_q <= DIR_RETRACT;
              end else if (ins_done) begin
                pickLRx_q <= XIN10;
                state_q   <= P_IN;
              end else begin
                pickLRx_q <= pickLRx_q - XSTEP10;
              end
            end else if (ret_done) begin
              pickLRx_q <= XOUT10;
              state_q   <= P_OUT;
            end else begin
              pickLRx_q <= pickLRx_q + XSTEP10;
            end
          end
          P_IN: begin
            if (attempt) begin
              state_q   <= P_TRY;
              openner_q <= 1'b0;
              try_cnt_q <= TRY_LD;
            end else if (keycode == KEY_A) begin
              state_q <= P_MOVE;
              dir_q   <= DIR_RETRACT;
            end else begin
              pickY_q <= y_key_d;
            end
          end
          P_TRY: begin
            if (try_cnt_q == '0) begin
              openner_q <= 1'b1;
              state_q   <= P_IN;
            end else begin
              try_cnt_q <= try_cnt_q - 8'd1;
            end
          end
          default: state_q <= P_OUT;
        endcase
      end
    end
  end

  assign pickY      = pickY_q;
  assign pickLRx    = pickLRx_q;
  assign openner    = openner_q;
  assign pick_state = state_q;

endmodule

// File: tb/tb_pick_controller.sv
// Frame-level scoreboard bench for pick_controller: a behavioural model pushes
// the expected outputs for each frame, and they are popped against the DUT.
module tb_pick_controller;

  logic       Clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       level_active = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] pickY, pickLRx;
  logic       openner;
  logic [1:0] pick_state;

  pick_controller dut (
    .Clk          (Clk),
    .reset        (reset),
    .frame_clk    (frame_clk),
    .level_active (level_active),
    .keycode      (keycode),
    .pickY        (pickY),
    .pickLRx      (pickLRx),
    .openner      (openner),
    .pick_state   (pick_state)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0] y;
    logic [9:0] x;
    logic       op;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   frame_no = 0;

  // Model state: st 0=OUT 1=MOVE 2=IN 3=TRY; dir 0=insert 1=retract.
  int m_x, m_y, m_st, m_dir, m_cnt;
  bit m_open, m_armed;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 600; m_y = 46; m_st = 0; m_dir = 0; m_cnt = 0;
    m_open = 1; m_armed = 1;
  endtask

  function automatic int y_move(input int y, input logic [7:0] k);
    int r;
    r = y;
    if (k == 8'h1A) r = (y - 4 < 32) ? 32 : y - 4;
    if (k == 8'h16) r = (y + 4 > 479) ? 479 : y + 4;
    return r;
  endfunction

  task automatic model_tick(input logic [7:0] k, input logic lv);
    if (k != 8'h2C) m_armed = 1;
    if (!lv) begin
      m_open = 1; m_cnt = 0;
      if (m_st == 1 && m_dir == 1) begin
        if (m_x + 8 >= 600) begin m_x = 600; m_st = 0; end
        else m_x = m_x + 8;
      end else if (m_st != 0) begin
        m_st = 1; m_dir = 1;
      end
      return;
    end
    case (m_st)
      0: begin
        m_y = y_move(m_y, k);
        if (k == 8'h07) begin m_st = 1; m_dir = 0; end
      end
      1: begin
        if (m_dir == 0) begin
          if (k == 8'h04) m_dir = 1;
          else if (m_x - 8 <= 480) begin m_x = 480; m_st = 2; end
          else m_x = m_x - 8;
        end else begin
          if (m_x + 8 >= 600) begin m_x = 600; m_st = 0; end
          else m_x = m_x + 8;
        end
      end
      2: begin
        if (k == 8'h2C && m_armed) begin
          m_st = 3; m_open = 0; m_cnt = 1; m_armed = 0;
        end else if (k == 8'h04) begin
          m_st = 1; m_dir = 1;
        end else m_y = y_move(m_y, k);
      end
      default: begin
        if (m_cnt == 0) begin m_open = 1; m_st = 2; end
        else m_cnt = m_cnt - 1;
      end
    endcase
  endtask

  task automatic push_model();
    exp_t e;
    e.y = 10'(m_y); e.x = 10'(m_x); e.op = m_open; e.st = 2'(m_st);
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("%s f%0d pickY", tag, frame_no), 32'(pickY), 32'(e.y));
    chk($sformatf("%s f%0d pickLRx", tag, frame_no), 32'(pickLRx), 32'(e.x));
    chk($sformatf("%s f%0d openner", tag, frame_no), 32'(openner), 32'(e.op));
    chk($sformatf("%s f%0d state", tag, frame_no), 32'(pick_state), 32'(e.st));
  endtask

  task automatic frame(input string tag, input logic [7:0] k, input logic lv);
    keycode = k;
    level_active = lv;
    repeat (2) @(posedge Clk);
    frame_clk = 1'b1;
    repeat (4) @(posedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(posedge Clk);
    frame_no++;
    model_tick(k, lv);
    push_model();
    @(negedge Clk);
    pop_check(tag);
  endtask

  task automatic frames(input string tag, input int n, input logic [7:0] k, input logic lv);
    for (int i = 0; i < n; i++) frame(tag, k, lv);
  endtask

  task automatic reset_pulse(input string tag, input int cycles);
    @(posedge Clk);
    reset = 1'b0;
    repeat (cycles) @(posedge Clk);
    model_reset();
    push_model();
    @(negedge Clk);
    pop_check(tag);
    reset = 1'b1;
    @(posedge Clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lows;
    model_reset();

    // 1: reset then idle frames
    reset_pulse("reset", 3);
    frames("idle", 10, 8'h00, 1'b0);

    // 2: insert
    frames("insert", 16, 8'h07, 1'b1);
    chk("insert_x480", 32'(pickLRx), 32'd480);
    chk("insert_in", 32'(pick_state), 32'd2);

    // 3: vertical moves with saturation
    frames("up", 5, 8'h1A, 1'b1);
    chk("up_sat", 32'(pickY), 32'd32);
    frames("down", 113, 8'h16, 1'b1);
    chk("down_sat", 32'(pickY), 32'd479);

    // 4: single attempt per Space press; A ignored while trying
    lows = 0;
    for (int i = 0; i < 6; i++) begin
      frame("space", 8'h2C, 1'b1);
      if (openner == 1'b0) lows++;
    end
    chk("space_low_frames", 32'(lows), 32'd2);
    frame("release", 8'h00, 1'b1);
    frame("space2", 8'h2C, 1'b1);
    chk("space2_open", 32'(openner), 32'd0);
    frames("try_A", 2, 8'h04, 1'b1);
    frame("after_try", 8'h00, 1'b1);
    chk("after_try_in", 32'(pick_state), 32'd2);

    // 5: level drop forces retract; D ignored
    frames("drop", 16, 8'h07, 1'b0);
    chk("drop_x600", 32'(pickLRx), 32'd600);
    frames("drop_hold", 3, 8'h07, 1'b0);

    // 6: reset mid-insert and mid-try
    frames("ins520", 11, 8'h07, 1'b1);
    chk("ins520_x", 32'(pickLRx), 32'd520);
    reset_pulse("rst_ins", 1);
    frames("reinsert", 16, 8'h07, 1'b1);
    frame("try_rst", 8'h2C, 1'b1);
    chk("try_rst_open", 32'(openner), 32'd0);
    reset_pulse("rst_try", 1);
    keycode = 8'h00;
    frames("post_rst", 2, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
